// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the program loader.
// The DEF_* values are the default memory geometry.
package program_loader_pkg;

  localparam int DEF_MEM_ADDR_SIZE = 5;
  localparam int DEF_WORD_SIZE     = 16;
  localparam int DEF_MEM_SIZE      = 32;
  localparam int CHECKSUM_SIZE     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/loader_checksum.sv
// Modular (carry-discarding) word accumulator with synchronous clear and add enable.
// sum_next exposes the post-add value so a final compare needs no extra cycle.
module loader_checksum
  import program_loader_pkg::*;
#(
  parameter int WIDTH = CHECKSUM_SIZE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             add_en,
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] sum_next
);

  assign sum_next = sum + word;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum_next;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams host words into memory from LOAD_BASE; the optional readback checksum pass
// is compiled in with LOADER_VERIFY_EN.
// state  | meaning
// IDLE   | waiting for start_load
// LOAD   | accepting words, one write strobe per accepted word
// VERIFY | sweeping written addresses and summing read data
// DONE   | load_complete pulse is visible this cycle
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int MEM_SIZE      = DEF_MEM_SIZE,
  parameter int LOAD_BASE     = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start_load,
  input  logic [MEM_ADDR_SIZE:0]   length,
  input  logic                     in_valid,
  input  logic [WORD_SIZE-1:0]     in_data,
  output logic                     in_ready,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]     mem_write_data,
  output logic                     mem_write,
  input  logic [WORD_SIZE-1:0]     mem_read_data,
  output logic                     busy,
  output logic                     load_complete,
  output logic [MEM_ADDR_SIZE:0]   words_loaded,
  output logic                     verify_error
);

  localparam int CW = MEM_ADDR_SIZE + 1;
  localparam logic [CW-1:0]            MEM_SIZE_C = CW'(MEM_SIZE);
  localparam logic [MEM_ADDR_SIZE-1:0] BASE_ADDR  = MEM_ADDR_SIZE'(LOAD_BASE);
  localparam logic [MEM_ADDR_SIZE-1:0] LAST_ADDR  = MEM_ADDR_SIZE'(MEM_SIZE - 1);

  function automatic logic [MEM_ADDR_SIZE-1:0] wrap_inc(input logic [MEM_ADDR_SIZE-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + MEM_ADDR_SIZE'(1);
  endfunction

  loader_state_t            state;
  logic [CW-1:0]            load_len;
  logic [MEM_ADDR_SIZE-1:0] wr_ptr;
  logic [CW-1:0]            len_clamped;
  logic                     transfer;

  assign len_clamped = (length > MEM_SIZE_C) ? MEM_SIZE_C : length;
  assign in_ready    = (state == ST_LOAD) && (words_loaded < load_len);
  assign transfer    = in_valid && in_ready;

`ifdef LOADER_VERIFY_EN
  logic                     chk_clear;
  logic [CW-1:0]            ver_cnt;
  logic                     addr_active;
  logic                     rd_en;
  logic [CHECKSUM_SIZE-1:0] load_sum;
  logic [CHECKSUM_SIZE-1:0] rb_sum_unused;
  logic [CHECKSUM_SIZE-1:0] rb_next;
  logic [CHECKSUM_SIZE-1:0] load_next_unused;

  assign chk_clear = (state == ST_IDLE) && start_load;

  loader_checksum #(.WIDTH(CHECKSUM_SIZE)) u_load_sum (
    .clock    (clock),
    .reset    (reset),
    .clear    (chk_clear),
    .add_en   (transfer),
    .word     (CHECKSUM_SIZE'(in_data)),
    .sum      (load_sum),
    .sum_next (load_next_unused)
  );

  loader_checksum #(.WIDTH(CHECKSUM_SIZE)) u_read_sum (
    .clock    (clock),
    .reset    (reset),
    .clear    (chk_clear),
    .add_en   (rd_en),
    .word     (CHECKSUM_SIZE'(mem_read_data)),
    .sum      (rb_sum_unused),
    .sum_next (rb_next)
  );
`else
  logic read_data_unused;
  assign read_data_unused = ^mem_read_data;
  assign verify_error     = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      load_len       <= '0;
      wr_ptr         <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      busy           <= 1'b0;
      load_complete  <= 1'b0;
      words_loaded   <= '0;
`ifdef LOADER_VERIFY_EN
      ver_cnt        <= '0;
      addr_active    <= 1'b0;
      rd_en          <= 1'b0;
      verify_error   <= 1'b0;
`endif
    end else begin
      mem_write     <= 1'b0;
      load_complete <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_load) begin
            load_len     <= len_clamped;
            words_loaded <= '0;
            wr_ptr       <= BASE_ADDR;
`ifdef LOADER_VERIFY_EN
            verify_error <= 1'b0;
`endif
            if (len_clamped == '0) begin
              state         <= ST_DONE;
              load_complete <= 1'b1;
            end else begin
              state <= ST_LOAD;
              busy  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (transfer) begin
            mem_addr       <= wr_ptr;
            mem_write_data <= in_data;
            mem_write      <= 1'b1;
            wr_ptr         <= wrap_inc(wr_ptr);
            words_loaded   <= words_loaded + CW'(1);
          end else if (words_loaded == load_len) begin
            // one cycle after the last accept, so its strobe is already out
`ifdef LOADER_VERIFY_EN
            state       <= ST_VERIFY;
            mem_addr    <= BASE_ADDR;
            ver_cnt     <= CW'(1);
            addr_active <= 1'b1;
`else
            state         <= ST_DONE;
            load_complete <= 1'b1;
            busy          <= 1'b0;
`endif
          end
        end
`ifdef LOADER_VERIFY_EN
        ST_VERIFY: begin
          rd_en <= addr_active;
          if (ver_cnt < load_len) begin
            mem_addr    <= wrap_inc(mem_addr);
            ver_cnt     <= ver_cnt + CW'(1);
            addr_active <= 1'b1;
          end else begin
            addr_active <= 1'b0;
          end
          // read data trails its address by one cycle
          if (rd_en && !addr_active) begin
            verify_error  <= (rb_next != load_sum);
            state         <= ST_DONE;
            load_complete <= 1'b1;
            busy          <= 1'b0;
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
